// File: rtl/scan_chain_tester_pkg.sv
// ----------------------------------------------------------------------------
// scan_chain_tester_pkg
//   Definitions shared by the scan chain tester: default chain and error
//   counter widths, the controller state encoding, and a helper that sizes
//   the shift-position counter.
// ----------------------------------------------------------------------------
package scan_chain_tester_pkg;

    localparam int CHAIN_LEN_DEF = 8;
    localparam int CNT_W_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_UNLOAD  = 2'd3
    } state_t;

    // Width of a counter that steps 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_result_chk.sv
// ----------------------------------------------------------------------------
// scan_result_chk
//   Registers each unloaded word, compares it against the expected word and
//   keeps a saturating count of failing results.
//
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   chk_en    in   a complete word is available this cycle
//   word      in   unloaded word (bit i = captured flop i)
//   expected  in   expected word for this result
//   res_valid out  one-cycle strobe following chk_en
//   res_data  out  last unloaded word, held until the next result
//   res_pass  out  res_data matched its expected word
//   err_cnt   out  failing results, sticks at all-ones
// ----------------------------------------------------------------------------
module scan_result_chk #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 chk_en,
    input  logic [CHAIN_LEN-1:0] word,
    input  logic [CHAIN_LEN-1:0] expected,
    output logic                 res_valid,
    output logic [CHAIN_LEN-1:0] res_data,
    output logic                 res_pass,
    output logic [CNT_W-1:0]     err_cnt
);

    logic match;

    assign match = (word == expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_pass  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            res_valid <= chk_en;
            if (chk_en) begin
                res_data <= word;
                res_pass <= match;
                if (!match && (err_cnt != {CNT_W{1'b1}}))
                    err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/scan_chain_tester.sv
// ----------------------------------------------------------------------------
// scan_chain_tester
//   Tester-side controller for a scan chain: shifts each pattern in, applies
//   one functional capture cycle, then shifts the captured word out while the
//   next pattern (if any) is shifted in, and checks it against its expectation.
//
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   pat_valid  in   pattern source has a pattern
//   pat_ready  out  controller accepts a pattern this cycle
//   pat_data   in   pattern, bit i ends up in chain flop i
//   exp_data   in   expected captured word for the pattern
//   scan_in    out  serial data into the chain head (registered)
//   scan_en    out  1 = shift, 0 = functional capture (registered)
//   scan_out   in   serial data from chain flop 0
//   res_valid  out  one-cycle result strobe
//   res_data   out  unloaded captured word, bit i = flop i
//   res_pass   out  res_data matched the expectation
//   err_cnt    out  saturating count of failing results
//   busy       out  controller not idle
//
//   state   | meaning
//   --------+----------------------------------------------------------------
//   IDLE    | chain quiet, waiting for a pattern
//   SHIFT   | shifting load_reg in; also unloading previous capture if unload_act
//   CAPTURE | one functional clock into the chain
//   UNLOAD  | shifting the last capture out with scan_in held low
// ----------------------------------------------------------------------------
module scan_chain_tester
    import scan_chain_tester_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_data,
    input  logic [CHAIN_LEN-1:0] exp_data,
    output logic                 scan_in,
    output logic                 scan_en,
    input  logic                 scan_out,
    output logic                 res_valid,
    output logic [CHAIN_LEN-1:0] res_data,
    output logic                 res_pass,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 busy
);

    localparam int              SC_W = cnt_width(CHAIN_LEN);
    localparam logic [SC_W-1:0] LAST = SC_W'(CHAIN_LEN - 1);

    state_t                 state, state_nxt;
    logic [SC_W-1:0]        cnt, cnt_nxt;
    logic [CHAIN_LEN-1:0]   load_reg, load_nxt;
    logic [CHAIN_LEN-1:0]   ld_exp, ld_exp_nxt;
    logic [CHAIN_LEN-1:0]   chk_exp, chk_exp_nxt;
    logic [CHAIN_LEN-1:0]   cap_reg, cap_nxt;
    logic [CHAIN_LEN-1:0]   pend_data, pend_data_nxt;
    logic [CHAIN_LEN-1:0]   pend_exp, pend_exp_nxt;
    logic                   pend_full, pend_full_nxt;
    logic                   unload_act, unload_nxt;
    logic                   scan_en_nxt, scan_in_nxt;
    logic                   emit;
    logic                   xfer;

    // Held low during reset so the source never sees a handshake it cannot complete.
    assign pat_ready = rst_n &&
                       ((state == ST_IDLE) ||
                        (((state == ST_SHIFT) || (state == ST_CAPTURE)) && !pend_full));
    assign xfer      = pat_valid && pat_ready;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        load_nxt      = load_reg;
        ld_exp_nxt    = ld_exp;
        chk_exp_nxt   = chk_exp;
        cap_nxt       = cap_reg;
        pend_data_nxt = pend_data;
        pend_exp_nxt  = pend_exp;
        pend_full_nxt = pend_full;
        unload_nxt    = unload_act;
        emit          = 1'b0;

        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    load_nxt   = pat_data;
                    ld_exp_nxt = exp_data;
                    unload_nxt = 1'b0;
                    cnt_nxt    = '0;
                    state_nxt  = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (unload_act)
                    cap_nxt[cnt] = scan_out;
                if (xfer) begin
                    pend_data_nxt = pat_data;
                    pend_exp_nxt  = exp_data;
                    pend_full_nxt = 1'b1;
                end
                if (cnt == LAST) begin
                    emit      = unload_act;
                    cnt_nxt   = '0;
                    state_nxt = ST_CAPTURE;
                end else begin
                    cnt_nxt = cnt + SC_W'(1);
                end
            end

            ST_CAPTURE: begin
                // The capture just completed belongs to the pattern in ld_exp.
                chk_exp_nxt = ld_exp;
                cnt_nxt     = '0;
                if (pend_full) begin
                    load_nxt      = pend_data;
                    ld_exp_nxt    = pend_exp;
                    pend_full_nxt = 1'b0;
                    unload_nxt    = 1'b1;
                    state_nxt     = ST_SHIFT;
                end else if (xfer) begin
                    // Pattern offered in the capture cycle goes straight to loading.
                    load_nxt   = pat_data;
                    ld_exp_nxt = exp_data;
                    unload_nxt = 1'b1;
                    state_nxt  = ST_SHIFT;
                end else begin
                    state_nxt = ST_UNLOAD;
                end
            end

            ST_UNLOAD: begin
                cap_nxt[cnt] = scan_out;
                if (cnt == LAST) begin
                    emit      = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + SC_W'(1);
                end
            end

            default: state_nxt = ST_IDLE;
        endcase

        // Chain pins are registered from next-cycle values so they are glitch-free.
        scan_en_nxt = (state_nxt == ST_SHIFT) || (state_nxt == ST_UNLOAD);
        scan_in_nxt = (state_nxt == ST_SHIFT) ? load_nxt[cnt_nxt] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            load_reg   <= '0;
            ld_exp     <= '0;
            chk_exp    <= '0;
            cap_reg    <= '0;
            pend_data  <= '0;
            pend_exp   <= '0;
            pend_full  <= 1'b0;
            unload_act <= 1'b0;
            scan_en    <= 1'b0;
            scan_in    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            load_reg   <= load_nxt;
            ld_exp     <= ld_exp_nxt;
            chk_exp    <= chk_exp_nxt;
            cap_reg    <= cap_nxt;
            pend_data  <= pend_data_nxt;
            pend_exp   <= pend_exp_nxt;
            pend_full  <= pend_full_nxt;
            unload_act <= unload_nxt;
            scan_en    <= scan_en_nxt;
            scan_in    <= scan_in_nxt;
        end
    end

    // The word includes the bit sampled at the emitting edge, hence cap_nxt.
    scan_result_chk #(
        .CHAIN_LEN (CHAIN_LEN),
        .CNT_W     (CNT_W)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .chk_en    (emit),
        .word      (cap_nxt),
        .expected  (chk_exp),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_pass  (res_pass),
        .err_cnt   (err_cnt)
    );

endmodule
